// File: rtl/axi_write_arbiter_if.sv
// Bundled AXI4 write channels around the arbiter: NUM_PORTS requester lanes (s_*)
// plus the single shared memory-side port (m_*). The master modport is the
// arbiter's own view (it masters the memory port); slave is the surrounding system.
interface axi_write_arbiter_if #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128
);
  localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

  // Requester side, port p in slice p
  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0] s_AWADDR;
  logic [NUM_PORTS*8-1:0]              s_AWLEN;
  logic [NUM_PORTS*3-1:0]              s_AWSIZE;
  logic [NUM_PORTS-1:0]                s_AWVALID;
  logic [NUM_PORTS-1:0]                s_AWREADY;
  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_WDATA;
  logic [NUM_PORTS*StrbWidth-1:0]      s_WSTRB;
  logic [NUM_PORTS-1:0]                s_WLAST;
  logic [NUM_PORTS-1:0]                s_WVALID;
  logic [NUM_PORTS-1:0]                s_WREADY;
  logic [NUM_PORTS*2-1:0]              s_BRESP;
  logic [NUM_PORTS-1:0]                s_BVALID;

  // Shared memory-side port
  logic [AXI_ADDR_WIDTH-1:0] m_AWADDR;
  logic [7:0]                m_AWLEN;
  logic [2:0]                m_AWSIZE;
  logic                      m_AWVALID;
  logic                      m_AWREADY;
  logic [AXI_DATA_WIDTH-1:0] m_WDATA;
  logic [StrbWidth-1:0]      m_WSTRB;
  logic                      m_WLAST;
  logic                      m_WVALID;
  logic                      m_WREADY;
  logic [1:0]                m_BRESP;
  logic                      m_BVALID;
  logic                      m_BREADY;

  modport master (
    input  s_AWADDR, s_AWLEN, s_AWSIZE, s_AWVALID, s_WDATA, s_WSTRB, s_WLAST, s_WVALID,
    output s_AWREADY, s_WREADY, s_BRESP, s_BVALID,
    output m_AWADDR, m_AWLEN, m_AWSIZE, m_AWVALID, m_WDATA, m_WSTRB, m_WLAST, m_WVALID,
    output m_BREADY,
    input  m_AWREADY, m_WREADY, m_BRESP, m_BVALID
  );

  modport slave (
    output s_AWADDR, s_AWLEN, s_AWSIZE, s_AWVALID, s_WDATA, s_WSTRB, s_WLAST, s_WVALID,
    input  s_AWREADY, s_WREADY, s_BRESP, s_BVALID,
    input  m_AWADDR, m_AWLEN, m_AWSIZE, m_AWVALID, m_WDATA, m_WSTRB, m_WLAST, m_WVALID,
    input  m_BREADY,
    output m_AWREADY, m_WREADY, m_BRESP, m_BVALID
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port among NUM_PORTS requesters.
// One transaction in flight: grant is held from AW acceptance until B returns.
// Payload is never registered; AW/W/B pass through from the granted port.
module axi_write_arbiter #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  localparam int unsigned GrantWidth    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned StrbWidth     = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rstN,
  axi_write_arbiter_if.master       bus,
  output logic [GrantWidth-1:0]     grant,
  output logic                      busy,
  output logic                      protocolError,
  output logic [31:0]               txCount
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                  state_q, state_d;
  logic [GrantWidth-1:0]   grant_q, grant_d;
  logic [GrantWidth-1:0]   last_grant_q, last_grant_d;
  logic [8:0]              beat_cnt_q, beat_cnt_d;
  logic [7:0]              len_q, len_d;
  logic                    err_q, err_d;
  logic [31:0]             tx_count_q, tx_count_d;

  logic [GrantWidth-1:0]   pick, cand;
  logic [NUM_PORTS-1:0]    sel;
  logic                    in_addr, in_data, in_resp, aw_hs, w_hs;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr [NUM_PORTS];
  logic [7:0]                aw_len  [NUM_PORTS];
  logic [2:0]                aw_size [NUM_PORTS];
  logic [AXI_DATA_WIDTH-1:0] w_data  [NUM_PORTS];
  logic [StrbWidth-1:0]      w_strb  [NUM_PORTS];

  // Flat per-port buses viewed as arrays, plus one-hot decode of the owner
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign aw_addr[p] = bus.s_AWADDR[p*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign aw_len[p]  = bus.s_AWLEN[p*8 +: 8];
    assign aw_size[p] = bus.s_AWSIZE[p*3 +: 3];
    assign w_data[p]  = bus.s_WDATA[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign w_strb[p]  = bus.s_WSTRB[p*StrbWidth +: StrbWidth];
    assign sel[p]     = (grant_q == GrantWidth'(p));
    assign bus.s_BRESP[p*2 +: 2] = (sel[p] && in_resp) ? bus.m_BRESP : 2'b00;
  end

  assign in_addr = (state_q == StAddr);
  assign in_data = (state_q == StData);
  assign in_resp = (state_q == StResp);
  assign aw_hs   = in_addr & bus.s_AWVALID[grant_q] & bus.m_AWREADY;
  assign w_hs    = in_data & bus.s_WVALID[grant_q] & bus.m_WREADY;

  // Payload always follows the granted port; only VALID/READY are phase-gated
  assign bus.m_AWADDR  = aw_addr[grant_q];
  assign bus.m_AWLEN   = aw_len[grant_q];
  assign bus.m_AWSIZE  = aw_size[grant_q];
  assign bus.m_AWVALID = in_addr & bus.s_AWVALID[grant_q];
  assign bus.m_WDATA   = w_data[grant_q];
  assign bus.m_WSTRB   = w_strb[grant_q];
  assign bus.m_WLAST   = bus.s_WLAST[grant_q];
  assign bus.m_WVALID  = in_data & bus.s_WVALID[grant_q];
  assign bus.m_BREADY  = in_resp;
  assign bus.s_AWREADY = sel & {NUM_PORTS{in_addr & bus.m_AWREADY}};
  assign bus.s_WREADY  = sel & {NUM_PORTS{in_data & bus.m_WREADY}};
  assign bus.s_BVALID  = sel & {NUM_PORTS{in_resp & bus.m_BVALID}};

  assign grant         = grant_q;
  assign busy          = (state_q != StIdle);
  assign protocolError = err_q;
  assign txCount       = tx_count_q;

  // Round-robin pick: first requester searching upward from last_grant+1.
  // Walking downward and overwriting leaves the closest candidate.
  always_comb begin
    pick = last_grant_q;
    cand = last_grant_q;
    for (int unsigned i = NUM_PORTS; i >= 1; i--) begin
      cand = GrantWidth'((32'(last_grant_q) + i) % NUM_PORTS);
      if (bus.s_AWVALID[cand]) pick = cand;
    end
  end

  // Next-state and transaction bookkeeping
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    err_d        = err_q;
    tx_count_d   = tx_count_q;
    case (state_q)
      StIdle: begin
        if (|bus.s_AWVALID) begin
          grant_d    = pick;
          beat_cnt_d = '0;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (aw_hs) begin
          len_d   = aw_len[grant_q];
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (bus.s_WLAST[grant_q]) begin
            state_d = StResp;
            if (beat_cnt_q != {1'b0, len_q}) err_d = 1'b1;
          end else if (beat_cnt_q == {1'b0, len_q}) begin
            // Missing WLAST is flagged but never synthesised; keep waiting for it
            err_d = 1'b1;
          end
        end
      end
      StResp: begin
        if (bus.m_BVALID) begin
          last_grant_d = grant_q;
          tx_count_d   = tx_count_q + 32'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last_grant resets to the top port so port 0 wins first
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GrantWidth'(NUM_PORTS - 1);
      beat_cnt_q   <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      tx_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      err_q        <= err_d;
      tx_count_q   <= tx_count_d;
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: directed transactions push expected
// AW/W/B items in hand-worked grant order; a negedge monitor pops and compares.
module tb_axi_write_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int Budget = 400;

  typedef struct {int port; logic [31:0] addr; logic [7:0] len;} aw_exp_t;
  typedef struct {logic [DW-1:0] data; logic [SW-1:0] strb; logic last;} w_exp_t;
  typedef struct {int port; logic [1:0] resp;} b_exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  grant;
  logic        busy;
  logic        protocol_error;
  logic [31:0] tx_count;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int aw_valid_cycles = 0;
  int w_seen = 0;
  int aw_cycle [NP];
  int b_cycle [NP];
  logic abort = 1'b0;
  logic w_toggle = 1'b0;

  aw_exp_t awq[$];
  w_exp_t  wq[$];
  b_exp_t  bq[$];

  axi_write_arbiter_if #(.NUM_PORTS(NP), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  axi_write_arbiter #(.NUM_PORTS(NP), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) u_dut (
    .clk          (clk),
    .rstN         (rstN),
    .bus          (bus),
    .grant        (grant),
    .busy         (busy),
    .protocolError(protocol_error),
    .txCount      (tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Memory-side slave: B answered in the cycle BREADY rises; port 3 gets SLVERR
  assign bus.m_BVALID = bus.m_BREADY;
  assign bus.m_BRESP  = (grant == 2'd3) ? 2'b10 : 2'b00;

  initial forever begin
    @(posedge clk);
    #1;
    bus.m_WREADY = w_toggle ? ~bus.m_WREADY : 1'b1;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event within %0d cycles, required one", name, Budget);
  endtask

  function automatic logic [DW-1:0] mk_data(input int p, input int tag, input int b);
    return {32'hDA7A_0000 + 32'(p), 32'(tag), 32'(b), 32'hC0FF_EE00 ^ 32'(b)};
  endfunction

  function automatic logic [31:0] mk_addr(input int p, input int tag);
    return 32'h8000_0000 | (32'(p) << 12) | (32'(tag) << 4);
  endfunction

  function automatic logic [SW-1:0] mk_strb(input int p);
    return 16'hF0F0 ^ 16'(p);
  endfunction

  task automatic expect_txn(input int p, input int tag, input int len, input int last_at,
                            input logic [1:0] resp);
    awq.push_back('{port: p, addr: mk_addr(p, tag), len: 8'(len)});
    for (int b = 0; b <= last_at; b++)
      wq.push_back('{data: mk_data(p, tag, b), strb: mk_strb(p), last: (b == last_at)});
    bq.push_back('{port: p, resp: resp});
  endtask

  task automatic drop_port(input int p);
    bus.s_AWVALID[p] = 1'b0;
    bus.s_WVALID[p]  = 1'b0;
    bus.s_WLAST[p]   = 1'b0;
  endtask

  // One requester transaction; called just after a rising edge
  task automatic requester(input int p, input int tag, input int len, input int last_at);
    int n;
    logic ok;
    bus.s_AWADDR[p*AW +: AW] = mk_addr(p, tag);
    bus.s_AWLEN[p*8 +: 8]    = 8'(len);
    bus.s_AWVALID[p]         = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = bus.s_AWREADY[p];
      @(posedge clk);
      #1;
      n++;
      if (abort) begin drop_port(p); return; end
      if (n > Budget) begin tmo("aw_wait"); drop_port(p); return; end
    end
    bus.s_AWVALID[p] = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      bus.s_WDATA[p*DW +: DW] = mk_data(p, tag, b);
      bus.s_WLAST[p]          = (b == last_at);
      bus.s_WVALID[p]         = 1'b1;
      n = 0;
      ok = 1'b0;
      while (!ok) begin
        @(negedge clk);
        ok = bus.s_WREADY[p];
        if (abort) begin drop_port(p); return; end
        @(posedge clk);
        #1;
        n++;
        if (abort) begin drop_port(p); return; end
        if (n > Budget) begin tmo("w_wait"); drop_port(p); return; end
      end
    end
    drop_port(p);
    n = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = bus.s_BVALID[p];
      @(posedge clk);
      #1;
      n++;
      if (abort) return;
      if (n > Budget) begin tmo("b_wait"); return; end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((awq.size() != 0 || wq.size() != 0 || bq.size() != 0 || busy) && n < Budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= Budget) tmo(name);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expectations whenever the DUT presents a handshake
  initial begin : monitor
    aw_exp_t a;
    w_exp_t  w;
    b_exp_t  e;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (bus.m_AWVALID) aw_valid_cycles++;
        if (bus.m_AWVALID && bus.m_AWREADY) begin
          if (awq.size() == 0) begin
            total++; bad++;
            $display("FAIL aw_extra: got AW addr %0h, required none", bus.m_AWADDR);
          end else begin
            a = awq.pop_front();
            chk("aw_grant", DW'(grant), DW'(a.port));
            chk("aw_addr", DW'(bus.m_AWADDR), DW'(a.addr));
            chk("aw_len", DW'(bus.m_AWLEN), DW'(a.len));
            aw_cycle[a.port] = cycle;
          end
        end
        if (bus.m_WVALID && bus.m_WREADY) begin
          w_seen++;
          if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL w_extra: got W data %0h, required none", bus.m_WDATA);
          end else begin
            w = wq.pop_front();
            chk("w_data", bus.m_WDATA, w.data);
            chk("w_strb", DW'(bus.m_WSTRB), DW'(w.strb));
            chk("w_last", DW'(bus.m_WLAST), DW'(w.last));
          end
        end
        if (|bus.s_BVALID) begin
          for (int p = 0; p < NP; p++) begin
            if (bus.s_BVALID[p]) begin
              b_cycle[p] = cycle;
              if (bq.size() == 0) begin
                total++; bad++;
                $display("FAIL b_extra: got BVALID on port %0d, required none", p);
              end else begin
                e = bq.pop_front();
                chk("b_port", DW'(p), DW'(e.port));
                chk("b_resp", DW'(bus.s_BRESP[p*2 +: 2]), DW'(e.resp));
              end
            end else begin
              chk("b_resp_other", DW'(bus.s_BRESP[p*2 +: 2]), '0);
            end
          end
        end
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_m_awvalid"}, DW'(bus.m_AWVALID), '0);
    chk({tag, "_m_wvalid"}, DW'(bus.m_WVALID), '0);
    chk({tag, "_m_bready"}, DW'(bus.m_BREADY), '0);
    chk({tag, "_s_awready"}, DW'(bus.s_AWREADY), '0);
    chk({tag, "_s_wready"}, DW'(bus.s_WREADY), '0);
    chk({tag, "_s_bvalid"}, DW'(bus.s_BVALID), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_grant"}, DW'(grant), '0);
    chk({tag, "_txcount"}, DW'(tx_count), '0);
    chk({tag, "_perr"}, DW'(protocol_error), '0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int base;
    rstN = 1'b0;
    bus.s_AWADDR = '0;  bus.s_AWLEN = '0;   bus.s_AWSIZE = {NP{3'd4}};
    bus.s_AWVALID = '0; bus.s_WDATA = '0;   bus.s_WLAST = '0;
    bus.s_WVALID = '0;  bus.m_AWREADY = 1'b1; bus.m_WREADY = 1'b1;
    for (int p = 0; p < NP; p++) bus.s_WSTRB[p*SW +: SW] = mk_strb(p);
    #2;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk);
    #1;

    // All four ports request 8-beat bursts; port 0 re-requests after its B
    expect_txn(0, 0, 7, 7, 2'b00);
    expect_txn(1, 1, 7, 7, 2'b00);
    expect_txn(2, 2, 7, 7, 2'b00);
    expect_txn(3, 3, 7, 7, 2'b10);
    expect_txn(0, 4, 7, 7, 2'b00);
    fork
      begin requester(0, 0, 7, 7); requester(0, 4, 7, 7); end
      requester(1, 1, 7, 7);
      requester(2, 2, 7, 7);
      requester(3, 3, 7, 7);
    join
    drain("drain_rr");
    chk("rr_txcount", DW'(tx_count), DW'(5));
    chk("rr_busy", DW'(busy), '0);

    // AWREADY low for 5 ADDR cycles, then WREADY toggling on a 4-beat burst
    bus.m_AWREADY = 1'b0;
    w_toggle = 1'b1;
    aw_valid_cycles = 0;
    base = w_seen;
    expect_txn(2, 5, 3, 3, 2'b00);
    fork
      requester(2, 5, 3, 3);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.m_AWVALID && n < Budget);
        if (n >= Budget) tmo("bp_awvalid");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 bus.m_AWREADY = 1'b1;
      end
    join
    w_toggle = 1'b0;
    drain("drain_bp");
    chk("bp_addr_cycles", DW'(aw_valid_cycles), DW'(6));
    chk("bp_beats", DW'(w_seen - base), DW'(4));
    chk("bp_txcount", DW'(tx_count), DW'(6));

    // AWLEN=7 but WLAST on beat 3: error flagged, transaction still completes
    chk("perr_before", DW'(protocol_error), '0);
    expect_txn(1, 6, 7, 3, 2'b00);
    requester(1, 6, 7, 3);
    drain("drain_perr");
    chk("perr_set", DW'(protocol_error), DW'(1));
    chk("perr_txcount", DW'(tx_count), DW'(7));
    expect_txn(0, 7, 1, 1, 2'b00);
    requester(0, 7, 1, 1);
    drain("drain_sticky");
    chk("perr_sticky", DW'(protocol_error), DW'(1));
    chk("sticky_txcount", DW'(tx_count), DW'(8));

    // Port 1 requests mid-burst of port 0: granted one IDLE cycle after port 0's B
    expect_txn(0, 8, 3, 3, 2'b00);
    expect_txn(1, 9, 1, 1, 2'b00);
    fork
      requester(0, 8, 3, 3);
      begin repeat (3) @(posedge clk); #1; requester(1, 9, 1, 1); end
    join
    drain("drain_late");
    chk("late_gap", DW'(aw_cycle[1] - b_cycle[0]), DW'(2));
    chk("late_txcount", DW'(tx_count), DW'(10));

    // Reset in the middle of a port-2 burst after three beats have passed
    base = w_seen;
    awq.push_back('{port: 2, addr: mk_addr(2, 10), len: 8'd7});
    for (int b = 0; b < 3; b++) wq.push_back('{data: mk_data(2, 10, b), strb: mk_strb(2), last: 1'b0});
    fork
      requester(2, 10, 7, 7);
      begin
        n = 0;
        while (w_seen < base + 3 && n < Budget) begin @(posedge clk); n++; end
        if (n >= Budget) tmo("rst_beats");
        #1 rstN = 1'b0;
        abort = 1'b1;
        #1;
        chk_idle_outputs("midrst");
      end
    join
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    rstN = 1'b1;
    chk("rst_awq_left", DW'(awq.size()), '0);
    chk("rst_wq_left", DW'(wq.size()), '0);
    @(posedge clk);
    #1;
    expect_txn(1, 11, 0, 0, 2'b00);
    requester(1, 11, 0, 0);
    drain("drain_post_rst");
    chk("post_rst_grant", DW'(grant), DW'(1));
    chk("post_rst_txcount", DW'(tx_count), DW'(1));

    chk("end_awq", DW'(awq.size()), '0);
    chk("end_wq", DW'(wq.size()), '0);
    chk("end_bq", DW'(bq.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Shares one AXI4 write port (AW/W/B channels) among `NUM_PORTS` waveform-recorder AXI masters, granting one complete write transaction at a time in round-robin order. It sits between the recorder instances and the single memory-controller/HP slave port. One transaction is outstanding at a time: a grant is held from AW acceptance until the B response is returned to the owning requester.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `AXI_ADDR_WIDTH`, 32: address width.
- `AXI_DATA_WIDTH`, 128: data width; strobe width is `AXI_DATA_WIDTH/8`.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  single clock for all logic.
- `rstN`  in  1  asynchronous active-low reset.
- `s_AWADDR`  in  NUM_PORTS*AXI_ADDR_WIDTH  per-port address, port p in slice p.
- `s_AWLEN`  in  NUM_PORTS*8  per-port burst length minus 1.
- `s_AWSIZE`  in  NUM_PORTS*3  per-port beat size.
- `s_AWVALID` in / `s_AWREADY` out  NUM_PORTS  per-port address handshake.
- `s_WDATA`  in  NUM_PORTS*AXI_DATA_WIDTH  per-port write data.
- `s_WSTRB`  in  NUM_PORTS*AXI_DATA_WIDTH/8  per-port strobes.
- `s_WLAST`, `s_WVALID` in / `s_WREADY` out  NUM_PORTS  per-port write-data handshake.
- `s_BRESP` out  NUM_PORTS*2 / `s_BVALID` out  NUM_PORTS  per-port response; requesters have no BREADY.
- `m_AWADDR`, `m_AWLEN`, `m_AWSIZE`, `m_AWVALID` out / `m_AWREADY` in: master address channel.
- `m_WDATA`, `m_WSTRB`, `m_WLAST`, `m_WVALID` out / `m_WREADY` in: master data channel.
- `m_BRESP` in 2, `m_BVALID` in / `m_BREADY` out: master response channel.
- `grant`  out  $clog2(NUM_PORTS)  index of current or last owner.
- `busy`  out  1  high whenever state is not IDLE.
- `protocolError`  out  1  sticky; set on a beat-count/WLAST mismatch; cleared only by reset.
- `txCount`  out  32  completed transactions; wraps modulo 2^32.

## Operation
- The state machine has four states: IDLE, ADDR, DATA, RESP.
- **IDLE:**
  - If any `s_AWVALID` is high, register `grant` as the first requesting port searched upward from `lastGrant+1` (mod NUM_PORTS), clear `beatCnt`, and go to ADDR.
  - Otherwise stay in IDLE.
- **ADDR:**
  - `m_AW*` = `s_AW*[grant]`.
  - `s_AWREADY[grant]` = `m_AWREADY`.
  - Latch `lenReg` = `s_AWLEN[grant]` on the handshake, then go to DATA.
- **DATA:**
  - `m_W*` = `s_W*[grant]`.
  - `s_WREADY[grant]` = `m_WREADY`.
  - Each W handshake increments the 9-bit `beatCnt`.
  - A handshake with WLAST moves to RESP.
  - Set `protocolError` if WLAST is present while `beatCnt != lenReg`, or if WLAST is absent while `beatCnt == lenReg`. In the second case the FSM stays in DATA until WLAST arrives; it never generates WLAST itself.
- **RESP:**
  - `m_BREADY` = 1.
  - `s_BVALID[grant]` = `m_BVALID`, and `s_BRESP[grant]` = `m_BRESP`.
  - On `m_BVALID`: `lastGrant` <= `grant`, `txCount`++, go to IDLE.
- **Non-granted ports:** all READY/BVALID outputs are 0 and `s_BRESP` is 0.
- **Master outputs outside their phase:** `m_AWVALID`, `m_WVALID` and `m_BREADY` are 0. `m_AWADDR` and `m_WDATA` are don't-care, but they are driven from the granted port to avoid extra muxing.
- **Late requests:** a requester that drops AWVALID before its grant is not penalised. One that raises AWVALID during another transaction waits.
- **Reset values:**
  - state = IDLE, `lastGrant` = NUM_PORTS-1, so port 0 wins first.
  - `grant` = 0, `txCount` = 0, `protocolError` = 0, `busy` = 0.
  - All VALID/READY outputs are 0.
- **Reset mid-transaction:** all outputs return immediately to their reset values. The block makes no attempt to complete the transfer; a system reset is expected to also reset the slave.

## Timing
- IDLE→ADDR takes 1 cycle after AWVALID is seen. The first `m_AWVALID` appears in the cycle after the request; the minimum request-to-AW latency is therefore 1 cycle.
- AW, W and B pass through combinationally, with no added latency beyond the grant register.
- Minimum single-beat transaction: 1 IDLE cycle + 1 ADDR + 1 DATA + 1 RESP = 4 cycles. Back-to-back grants are separated by exactly one IDLE cycle.
- The arbiter never registers payload, so throughput within a burst is 1 beat/cycle when both sides are ready.
- Fairness: with all ports requesting continuously, each port gets exactly one transaction per NUM_PORTS grants.

## Test plan
- **Reset:** assert `rstN`=0 mid-burst on port 2 → all `m_*VALID`, `s_*READY`, `s_BVALID` and `busy` go to 0 immediately; after release, a request on port 1 alone is granted with `grant`=1.
- **Simultaneous requests:** ports 0..3 all request 8-beat bursts (AWLEN=7) → grant order 0,1,2,3,0; each burst gives 8 `m_WVALID&m_WREADY` beats with data from the owning port; `txCount`=5.
- **Response routing:** slave returns BRESP=2'b10 on port 3's transaction → `s_BVALID[3]`=1 with `s_BRESP[3]`=2'b10 for that cycle only; other ports see 0.
- **Backpressure:** `m_AWREADY` held low 5 cycles, then `m_WREADY` toggling every cycle on a 4-beat burst → state stays ADDR 5 cycles; exactly 4 beats transferred; no beat duplicated.
- **Protocol error:** AWLEN=7 with WLAST on beat 3 → `protocolError`=1 and sticky; FSM proceeds to RESP and completes normally.
- **Late request:** port 0 mid-burst while port 1 requests → port 1 sees `s_AWREADY[1]`=0 until port 0's B completes, then is granted after one IDLE cycle.
